apb_regfile_completer: RTL and testbench
========================================

// Module: apb_regfile_completer
// PURPOSE
//  APB4 completer (slave end) fronting a bank of 32-bit control/status registers.
//  Supports programmable wait states, byte-strobed writes and error responses (PSLVERR).
//  Sits on the peripheral bus opposite the APB requester; register contents are exported
//  to the owning peripheral.
// PARAMETERS
//  ADDR_W       32             PADDR width
//  NUM_REGS     16             register count, power of two, >=2
//  WAIT_CYCLES  2              extra access-phase cycles before PREADY (0 = zero-wait)
//  RO_MASK      16'h0001       bit i set -> register i is read-only
//  ID_VALUE     32'hA5B0_0001  fixed value of register 0
// PORTS
//  PCLK     in   1              bus clock, all logic on rising edge
//  PRESETn  in   1              asynchronous active-low reset
//  PSEL     in   1              completer select
//  PENABLE  in   1              access phase
//  PWRITE   in   1              1 = write, 0 = read
//  PADDR    in   ADDR_W         byte address
//  PWDATA   in   32             write data
//  PSTRB    in   4              write byte-lane enables
//  PRDATA   out  32             read data, valid only while PREADY=1
//  PREADY   out  1              transfer completes this cycle
//  PSLVERR  out  1              error response, valid only while PREADY=1
//  regs_o   out  NUM_REGS*32    flattened register contents, reg i at [32*i +: 32]
// BEHAVIOUR
//  Reset:
//   - PREADY=0, PSLVERR=0, PRDATA=0; FSM to IDLE.
//   - All registers to 0, except reg 0 = ID_VALUE. Reset is async and may occur mid-transfer.
//  FSM states: IDLE, WAIT, RESP.
//   - IDLE: on PSEL & !PENABLE, latch PADDR/PWRITE/PWDATA/PSTRB and load cnt=WAIT_CYCLES.
//     Go to WAIT if WAIT_CYCLES>0, else RESP.
//   - WAIT: cnt decrements each cycle; when cnt==1, go to RESP.
//     PSEL low in WAIT: abort to IDLE; no write, no response.
//   - RESP: PREADY=1 for exactly one cycle; next state IDLE.
//  Outputs: PREADY, PSLVERR and PRDATA are registered, set on entry to RESP, and are 0 in all
//   other states.
//  Latency: access phase lasts WAIT_CYCLES+1 cycles; PREADY is high in the last one.
//   With WAIT_CYCLES=0, PREADY is high in the first access cycle.
//  Back-to-back: a setup phase in the cycle after RESP is accepted from IDLE; no idle gap.
//  Decode: idx = PADDR[2 +: log2(NUM_REGS)]. Error when any of:
//   - PADDR >= NUM_REGS*4
//   - PADDR[1:0] != 0
//   - write to a register with RO_MASK[idx]=1
//  Error response: PSLVERR=1 and PRDATA=0 in RESP; no register changes.
//  Write commit: at the clock edge ending RESP, only for PWRITE=1 with no error.
//   - Byte lane b is updated only if PSTRB[b]=1; PSTRB=0 is a legal no-op (OKAY).
//  Read: PRDATA = reg[idx] sampled on entry to RESP; PSTRB is ignored for reads.
//  Held signals: PADDR/PWRITE/PWDATA changes during the access phase are ignored
//   (latched values are used).
//  PENABLE seen in IDLE without a prior setup phase: ignored; PREADY stays 0.
//  regs_o reflects committed values; an update is visible the cycle after the RESP edge.
// STRUCTURE
//  - Package apb_pkg: state enum apb_cstate_t {IDLE, WAIT, RESP}; constants APB_STRB_W=4,
//    APB_DATA_W=32.
//  - Sub-module apb_completer_regs: register storage, byte-strobe write, read mux,
//    RO/ID handling.
//  - Top level: FSM, wait counter, decode/error logic, registered APB outputs.
// TESTING (WAIT_CYCLES=2 unless noted)
//  1. Reset, read 0x0 -> PREADY high on 3rd access cycle, PRDATA=A5B00001, PSLVERR=0.
//  2. Write 0x8 = DEADBEEF, PSTRB=4'b0101 after reg2 = 0 -> readback 00AD00EF,
//     regs_o[95:64]=00AD00EF.
//  3. Write 0x0 (RO), then read 0x40 and 0x6 -> each PSLVERR=1, PRDATA=0; reg 0 unchanged.
//  4. WAIT_CYCLES=0: back-to-back write 0x4=1234, read 0x4 -> PREADY on 1st access cycle each,
//     read returns 00001234.
//  5. PSEL dropped during WAIT of a write 0xC=FFFFFFFF -> no PREADY pulse, reg3 stays 0.
//  6. PRESETn low during WAIT -> outputs 0 immediately; after release, regs back to
//     reset values and next read completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and bus constants for the APB register-file completer.
package apb_pkg;

  localparam int unsigned APB_STRB_W = 4;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_cstate_t;

endpackage

// File: rtl/apb_completer_regs.sv
// Register storage for the APB completer: byte-strobed writes, combinational read mux,
// read-only protection and the fixed ID value held by register 0.
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int unsigned           NUM_REGS = 16,
  parameter int unsigned           IDX_W    = 4,
  parameter logic [NUM_REGS-1:0]   RO_MASK  = 16'h0001,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [APB_DATA_W-1:0]          wr_data,
  input  logic [APB_STRB_W-1:0]          wr_strb,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [APB_DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*APB_DATA_W-1:0] regs_o
);

  logic [NUM_REGS-1:0][APB_DATA_W-1:0] mem;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= (i == 0) ? ID_VALUE : '0;
      end
    end else if (wr_en && !RO_MASK[wr_idx]) begin
      for (int unsigned b = 0; b < APB_STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];
  assign regs_o  = mem;

endmodule

// File: rtl/apb_regfile_completer.sv
// APB4 completer with programmable wait states fronting a bank of 32-bit registers.
// Transfer FSM, wait counter, address decode/error checks and registered bus outputs.
module apb_regfile_completer
  import apb_pkg::*;
#(
  parameter int unsigned           ADDR_W      = 32,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           WAIT_CYCLES = 2,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = 16'h0001,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_W-1:0]              PADDR,
  input  logic [APB_DATA_W-1:0]          PWDATA,
  input  logic [APB_STRB_W-1:0]          PSTRB,
  output logic [APB_DATA_W-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*APB_DATA_W-1:0] regs_o
);

  localparam int unsigned     IDX_W      = $clog2(NUM_REGS);
  localparam int unsigned     CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

  apb_cstate_t state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wr_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_STRB_W-1:0] strb_q;

  logic                  setup;
  logic                  enter_resp;
  logic [ADDR_W-1:0]     dec_addr;
  logic                  dec_wr;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic                  commit;
  logic [APB_DATA_W-1:0] rd_data;

  assign setup = PSEL & ~PENABLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!PSEL)                     state_d = IDLE;
        else if (cnt_q == CNT_W'(1))   state_d = RESP;
        else                           cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && setup) begin
        addr_q  <= PADDR;
        wr_q    <= PWRITE;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
      end
    end
  end

  // Zero-wait transfers enter RESP straight from IDLE, before the latch is loaded,
  // so decode looks at the live bus in IDLE and the held copy otherwise.
  assign dec_addr   = (state_q == IDLE) ? PADDR  : addr_q;
  assign dec_wr     = (state_q == IDLE) ? PWRITE : wr_q;
  assign dec_idx    = dec_addr[2 +: IDX_W];
  assign dec_err    = (dec_addr >= ADDR_LIMIT) || (dec_addr[1:0] != 2'b00) ||
                      (dec_wr && RO_MASK[dec_idx]);
  assign enter_resp = (state_d == RESP);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= enter_resp;
      PSLVERR <= enter_resp && dec_err;
      PRDATA  <= (enter_resp && !dec_err && !dec_wr) ? rd_data : '0;
    end
  end

  assign commit = (state_q == RESP) && wr_q && !PSLVERR;

  apb_completer_regs #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .RO_MASK  (RO_MASK),
    .ID_VALUE (ID_VALUE)
  ) u_regs (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .wr_en   (commit),
    .wr_idx  (addr_q[2 +: IDX_W]),
    .wr_data (wdata_q),
    .wr_strb (strb_q),
    .rd_idx  (dec_idx),
    .rd_data (rd_data),
    .regs_o  (regs_o)
  );

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Randomised scoreboard bench for apb_regfile_completer: one 2-wait-state and one zero-wait instance.
module tb_apb_regfile_completer;

  localparam bit [15:0] RO  = 16'h0001;
  localparam bit [31:0] IDV = 32'hA5B0_0001;

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic         psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]  paddr = '0, pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1, pslverr0, pslverr1;
  logic [511:0] regs0, regs1;

  always #5 PCLK = ~PCLK;

  apb_regfile_completer #(.WAIT_CYCLES(2)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .regs_o(regs0));

  apb_regfile_completer #(.WAIT_CYCLES(0)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .regs_o(regs1));

  typedef struct {
    bit [31:0] rdata;
    bit        err;
    bit        chk_data;
  } exp_t;

  exp_t      q0[$], q1[$];
  bit [31:0] model0[16], model1[16];
  int        n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit spec_err(input bit [31:0] a, input bit w);
    return (a >= 32'd64) || (a[1:0] != 2'b00) || (w && RO[a[5:2]]);
  endfunction

  function automatic logic [511:0] flat(input int d);
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[32*i +: 32] = (d != 0) ? model1[i] : model0[i];
    return f;
  endfunction

  function automatic void reset_models();
    for (int i = 0; i < 16; i++) begin
      model0[i] = (i == 0) ? IDV : 32'h0;
      model1[i] = (i == 0) ? IDV : 32'h0;
    end
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] st);
    bit [31:0] m;
    m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (old & ~m) | (wd & m);
  endfunction

  // mode 0: normal transfer, 1: drop PSEL during WAIT, 2: assert reset during WAIT
  task automatic xfer(input int d, input bit wr, input bit [31:0] a, input bit [31:0] wd,
                      input bit [3:0] st, input int mode, input bit chk_regs);
    int        lat;
    int        cyc;
    bit        e;
    exp_t      x;
    bit [31:0] cur;
    lat = (d == 0) ? 3 : 1;
    cyc = 0;
    e   = spec_err(a, wr);
    @(posedge PCLK); #1;
    psel0 = (d == 0); psel1 = (d == 1); penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    if (mode == 0) begin
      cur        = (d != 0) ? model1[a[5:2]] : model0[a[5:2]];
      x.err      = e;
      x.rdata    = (e || wr) ? 32'h0 : cur;
      x.chk_data = e || !wr;
      if (d != 0) q1.push_back(x); else q0.push_back(x);
      if (wr && !e) begin
        if (d != 0) model1[a[5:2]] = merge(model1[a[5:2]], wd, st);
        else        model0[a[5:2]] = merge(model0[a[5:2]], wd, st);
      end
    end
    @(posedge PCLK); #1;
    penable = 1'b1;
    pwrite = 1'($urandom); paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom);
    if (mode == 0) begin
      do begin
        @(negedge PCLK);
        cyc++;
      end while (!((d != 0) ? pready1 : pready0) && cyc < 10);
      chk($sformatf("latency_d%0d_a%0h", d, a), cyc, lat);
      if (chk_regs) begin
        @(posedge PCLK); #1;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        chk($sformatf("regs_o_d%0d", d), (d != 0) ? regs1 : regs0, flat(d));
      end
    end else if (mode == 1) begin
      @(negedge PCLK);
      psel0 = 1'b0; penable = 1'b0;
      repeat (4) begin
        @(negedge PCLK);
        chk("abort_no_pready", pready0, 1'b0);
      end
    end else begin
      @(negedge PCLK);
      PRESETn = 1'b0;
      #1;
      reset_models();
      q0.delete(); q1.delete();
      chk("rst_pready",  pready0,  1'b0);
      chk("rst_pslverr", pslverr0, 1'b0);
      chk("rst_prdata",  prdata0,  32'h0);
      chk("rst_regs0",   regs0,    flat(0));
      chk("rst_regs1",   regs1,    flat(1));
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
    end
  endtask

  task automatic go_idle();
    @(posedge PCLK); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  // Scoreboard monitor: every PREADY pulse consumes one expected response.
  always @(negedge PCLK) begin
    exp_t e;
    if (PRESETn && pready0) begin
      if (q0.size() == 0) chk("unexpected_pready0", 1'b1, 1'b0);
      else begin
        e = q0.pop_front();
        chk("pslverr0", pslverr0, e.err);
        if (e.chk_data) chk("prdata0", prdata0, e.rdata);
      end
    end
    if (PRESETn && pready1) begin
      if (q1.size() == 0) chk("unexpected_pready1", 1'b1, 1'b0);
      else begin
        e = q1.pop_front();
        chk("pslverr1", pslverr1, e.err);
        if (e.chk_data) chk("prdata1", prdata1, e.rdata);
      end
    end
  end

  initial begin
    bit [31:0] a;
    int        d;
    reset_models();
    #12;
    chk("reset_pready0",  pready0,  1'b0);
    chk("reset_pslverr0", pslverr0, 1'b0);
    chk("reset_prdata0",  prdata0,  32'h0);
    chk("reset_regs0",    regs0,    flat(0));
    chk("reset_regs1",    regs1,    flat(1));
    @(negedge PCLK);
    PRESETn = 1'b1;

    // ID read, strobed write and readback
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b1);
    xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'b0101, 0, 1'b1);
    chk("regs0_reg2", regs0[95:64], 32'h00AD_00EF);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b1);

    // error responses
    xfer(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 0, 1'b1);
    xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b1);
    xfer(0, 1'b0, 32'h6, 32'h0, 4'hF, 0, 1'b1);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b1);

    // PENABLE without a setup phase is ignored
    @(posedge PCLK); #1;
    psel0 = 1'b1; penable = 1'b1; paddr = 32'h0; pwrite = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      chk("no_setup_pready", pready0, 1'b0);
    end
    go_idle();

    // zero-wait back-to-back
    xfer(1, 1'b1, 32'h4, 32'h0000_1234, 4'hF, 0, 1'b0);
    xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b1);
    chk("regs1_reg1", regs1[63:32], 32'h0000_1234);

    // aborted write leaves reg3 untouched
    xfer(0, 1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF, 1, 1'b0);
    xfer(0, 1'b0, 32'hC, 32'h0, 4'hF, 0, 1'b1);
    chk("regs0_reg3", regs0[127:96], 32'h0);

    // reset mid-transfer, then a normal read
    xfer(0, 1'b1, 32'h10, 32'h1111_2222, 4'hF, 0, 1'b1);
    xfer(0, 1'b1, 32'h14, 32'h3333_4444, 4'hF, 2, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b1);
    xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b1);

    for (int i = 0; i < 120; i++) begin
      d = (i % 3 == 2) ? 1 : 0;
      case ($urandom_range(0, 9))
        0:       a = $urandom_range(0, 255);
        1:       a = 32'h40 + 32'($urandom_range(0, 15)) * 4;
        2:       a = $urandom;
        default: a = 32'($urandom_range(0, 15)) * 4;
      endcase
      xfer(d, 1'($urandom), a, $urandom, 4'($urandom), 0, 1'($urandom));
    end
    go_idle();
    repeat (4) @(negedge PCLK);
    chk("final_regs0", regs0, flat(0));
    chk("final_regs1", regs1, flat(1));
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
